// File: rtl/exec_mem_unit_if.sv
// Bus bundle for the execute/memory stage: ALU, shifter and data-memory signals.
// The datapath drives through the master modport; exec_mem_unit sits on the slave side.
interface exec_mem_unit_if;
   logic [2:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic       alu_cin;
   logic [7:0] alu_out;
   logic       alu_co;
   logic       alu_z;
   logic [7:0] sh_data;
   logic [2:0] sh_count;
   logic       sh_dir;
   logic       sh_ro_bar;
   logic [7:0] sh_out;
   logic       sh_c;
   logic       sh_z;
   logic       mem_write;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   modport master (
      output alu_op, alu_a, alu_b, alu_cin,
      output sh_data, sh_count, sh_dir, sh_ro_bar,
      output mem_write, mem_wdata,
      input  alu_out, alu_co, alu_z,
      input  sh_out, sh_c, sh_z,
      input  mem_rdata
   );

   modport slave (
      input  alu_op, alu_a, alu_b, alu_cin,
      input  sh_data, sh_count, sh_dir, sh_ro_bar,
      input  mem_write, mem_wdata,
      output alu_out, alu_co, alu_z,
      output sh_out, sh_c, sh_z,
      output mem_rdata
   );
endinterface

// File: rtl/exec_mem_unit.sv
// Execute/memory stage: combinational ALU and barrel shifter plus a 256x8 data
// memory addressed by the ALU result (async read, clocked write, sync clear).
module exec_mem_unit (
   input  logic           clk,
   input  logic           reset,
   exec_mem_unit_if.slave bus
);

   logic [8:0]  alu_res_s;
   logic [15:0] sh_wide_s;
   logic [7:0]  sh_res_s;
   logic        sh_c_s;
   logic [7:0]  mem_q [256];
   logic [7:0]  mem_d [256];

   // ALU: bit 8 carries the carry-out on ADD and the borrow on SUB
   always_comb begin
      alu_res_s = 9'h000;
      case (bus.alu_op)
         3'b000:  alu_res_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_cin};
         3'b001:  alu_res_s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'h00, bus.alu_cin};
         3'b010:  alu_res_s = {1'b0, bus.alu_a & bus.alu_b};
         3'b011:  alu_res_s = {1'b0, bus.alu_a | bus.alu_b};
         3'b100:  alu_res_s = {1'b0, bus.alu_a ^ bus.alu_b};
         3'b101:  alu_res_s = {1'b0, bus.alu_a & ~bus.alu_b};
         3'b110:  alu_res_s = {1'b0, bus.alu_b};
         3'b111:  alu_res_s = {1'b0, bus.alu_a};
         default: alu_res_s = 9'h000;
      endcase
   end

   // Shifter: a 16-bit window makes the last bit shifted out land at a fixed position
   always_comb begin
      sh_wide_s = 16'h0000;
      sh_res_s  = 8'h00;
      sh_c_s    = 1'b0;
      case ({bus.sh_dir, bus.sh_ro_bar})
         2'b01: begin
            sh_wide_s = {8'h00, bus.sh_data} << bus.sh_count;
            sh_res_s  = sh_wide_s[7:0];
            sh_c_s    = sh_wide_s[8];
         end
         2'b11: begin
            sh_wide_s = {bus.sh_data, 8'h00} >> bus.sh_count;
            sh_res_s  = sh_wide_s[15:8];
            sh_c_s    = sh_wide_s[7];
         end
         2'b00: begin
            sh_wide_s = {bus.sh_data, bus.sh_data} << bus.sh_count;
            sh_res_s  = sh_wide_s[15:8];
            sh_c_s    = (bus.sh_count != 3'd0) ? sh_wide_s[8] : 1'b0;
         end
         2'b10: begin
            sh_wide_s = {bus.sh_data, bus.sh_data} >> bus.sh_count;
            sh_res_s  = sh_wide_s[7:0];
            sh_c_s    = (bus.sh_count != 3'd0) ? sh_wide_s[7] : 1'b0;
         end
         default: begin
            sh_wide_s = 16'h0000;
            sh_res_s  = 8'h00;
            sh_c_s    = 1'b0;
         end
      endcase
   end

   // Memory next-state: only the addressed location takes write data
   always_comb begin
      for (int i = 0; i < 256; i++) begin
         if (bus.mem_write && (alu_res_s[7:0] == i[7:0])) begin
            mem_d[i] = bus.mem_wdata;
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
   end

   // Memory array; reset clears every location and overrides a pending write
   always_ff @(posedge clk) begin
      for (int i = 0; i < 256; i++) begin
         if (reset) begin
            mem_q[i] <= 8'h00;
         end else begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign bus.alu_out   = alu_res_s[7:0];
   assign bus.alu_co    = alu_res_s[8];
   assign bus.alu_z     = (alu_res_s[7:0] == 8'h00);
   assign bus.sh_out    = sh_res_s;
   assign bus.sh_c      = sh_c_s;
   assign bus.sh_z      = (sh_res_s == 8'h00);
   assign bus.mem_rdata = mem_q[alu_res_s[7:0]];

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit: ALU, shifter, memory and reset.
module tb_exec_mem_unit;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   exec_mem_unit_if bus ();

   exec_mem_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_alu(input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic cin);
      bus.alu_op  = op;
      bus.alu_a   = a;
      bus.alu_b   = b;
      bus.alu_cin = cin;
      #1;
   endtask

   task automatic drive_sh(input logic [7:0] d, input logic [2:0] n,
                           input logic dir, input logic ro_bar);
      bus.sh_data   = d;
      bus.sh_count  = n;
      bus.sh_dir    = dir;
      bus.sh_ro_bar = ro_bar;
      #1;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.mem_write = 1'b0;
      bus.mem_wdata = 8'h00;
      drive_alu(3'b000, 8'h00, 8'h00, 1'b0);
      drive_sh(8'h00, 3'd0, 1'b0, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({bus.alu_out, bus.alu_co, bus.alu_z} !== {8'h00, 1'b1 ^ 1'b0 ^ 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL reset_alu got=%h/%b/%b exp=00/0/1", bus.alu_out, bus.alu_co, bus.alu_z);
      end
      checks++;
      if ({bus.sh_out, bus.sh_c, bus.sh_z} !== {8'h00, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_sh got=%h/%b/%b exp=00/0/1", bus.sh_out, bus.sh_c, bus.sh_z);
      end
      checks++;
      if (bus.mem_rdata !== 8'h00) begin
         failures++;
         $display("FAIL reset_mem got=%h exp=00", bus.mem_rdata);
      end
   endtask

   task automatic test_alu();
      logic [7:0] e_out [10];
      logic       e_co  [10];
      logic [2:0] ops   [10];
      logic [7:0] as    [10];
      logic [7:0] bs    [10];
      logic       cins  [10];
      ops = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
      as  = '{8'hFF,  8'hFF,  8'h3C,  8'h05,  8'h10,  8'hF0,  8'h50,  8'hFF,  8'hFF,  8'h9C};
      bs  = '{8'h01,  8'h01,  8'h4A,  8'h07,  8'h05,  8'h0F,  8'h0A,  8'h0F,  8'h0F,  8'h11};
      cins = '{1'b0,  1'b1,   1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1};
      e_out = '{8'h00, 8'h01, 8'h87, 8'hFE, 8'h0A, 8'h00, 8'h5A, 8'hF0, 8'hF0, 8'h9C};
      e_co  = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
      for (int i = 0; i < 10; i++) begin
         drive_alu(ops[i], as[i], bs[i], cins[i]);
         checks++;
         if ({bus.alu_out, bus.alu_co, bus.alu_z} !== {e_out[i], e_co[i], (e_out[i] == 8'h00)}) begin
            failures++;
            $display("FAIL alu_vec%0d op=%b got=%h/%b/%b exp=%h/%b/%b", i, ops[i],
                     bus.alu_out, bus.alu_co, bus.alu_z, e_out[i], e_co[i], (e_out[i] == 8'h00));
         end
      end
      drive_alu(3'b110, 8'hAB, 8'h00, 1'b1);
      checks++;
      if ({bus.alu_out, bus.alu_co, bus.alu_z} !== {8'h00, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL alu_passb got=%h/%b/%b exp=00/0/1", bus.alu_out, bus.alu_co, bus.alu_z);
      end
      drive_alu(3'b001, 8'h00, 8'hFF, 1'b1);
      checks++;
      if ({bus.alu_out, bus.alu_co, bus.alu_z} !== {8'h00, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL alu_sub_wrap got=%h/%b/%b exp=00/1/1", bus.alu_out, bus.alu_co, bus.alu_z);
      end
   endtask

   task automatic test_shifter();
      logic [7:0] ds    [9];
      logic [2:0] ns    [9];
      logic       dirs  [9];
      logic       ros   [9];
      logic [7:0] e_out [9];
      logic       e_c   [9];
      ds    = '{8'h81, 8'h81, 8'h81, 8'h02, 8'h81, 8'h81, 8'hB8, 8'hB6, 8'h96};
      ns    = '{3'd1,  3'd1,  3'd0,  3'd7,  3'd1,  3'd0,  3'd4,  3'd3,  3'd4};
      dirs  = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
      ros   = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
      e_out = '{8'h02, 8'hC0, 8'h81, 8'h00, 8'h03, 8'h81, 8'h0B, 8'hD6, 8'h69};
      e_c   = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
      for (int i = 0; i < 9; i++) begin
         drive_sh(ds[i], ns[i], dirs[i], ros[i]);
         checks++;
         if ({bus.sh_out, bus.sh_c, bus.sh_z} !== {e_out[i], e_c[i], (e_out[i] == 8'h00)}) begin
            failures++;
            $display("FAIL sh_vec%0d got=%h/%b/%b exp=%h/%b/%b", i,
                     bus.sh_out, bus.sh_c, bus.sh_z, e_out[i], e_c[i], (e_out[i] == 8'h00));
         end
      end
      drive_sh(8'hB6, 3'd4, 1'b1, 1'b1);
      checks++;
      if ({bus.sh_out, bus.sh_c} !== {8'h0B, 1'b0}) begin
         failures++;
         $display("FAIL sh_right_c0 got=%h/%b exp=0b/0", bus.sh_out, bus.sh_c);
      end
   endtask

   task automatic test_mem_write_read();
      drive_alu(3'b110, 8'h00, 8'h10, 1'b0);
      bus.mem_write = 1'b1;
      bus.mem_wdata = 8'hA5;
      @(posedge clk); #1;
      bus.mem_write = 1'b0;
      checks++;
      if (bus.mem_rdata !== 8'hA5) begin
         failures++;
         $display("FAIL mem_wr10 got=%h exp=a5", bus.mem_rdata);
      end
      drive_alu(3'b110, 8'h00, 8'h11, 1'b0);
      checks++;
      if (bus.mem_rdata !== 8'h00) begin
         failures++;
         $display("FAIL mem_rd11 got=%h exp=00", bus.mem_rdata);
      end
      drive_alu(3'b110, 8'h00, 8'h10, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.mem_rdata !== 8'hA5) begin
         failures++;
         $display("FAIL mem_hold10 got=%h exp=a5", bus.mem_rdata);
      end
   endtask

   task automatic test_same_cycle();
      drive_alu(3'b000, 8'h30, 8'h10, 1'b0);
      bus.mem_write = 1'b1;
      bus.mem_wdata = 8'h12;
      @(posedge clk); #1;
      bus.mem_wdata = 8'h34;
      #1;
      checks++;
      if (bus.mem_rdata !== 8'h12) begin
         failures++;
         $display("FAIL same_before got=%h exp=12", bus.mem_rdata);
      end
      @(posedge clk); #1;
      bus.mem_write = 1'b0;
      checks++;
      if (bus.mem_rdata !== 8'h34) begin
         failures++;
         $display("FAIL same_after got=%h exp=34", bus.mem_rdata);
      end
   endtask

   task automatic test_reset_discard();
      int nonzero;
      drive_alu(3'b111, 8'h20, 8'h00, 1'b0);
      bus.mem_write = 1'b1;
      bus.mem_wdata = 8'h3C;
      @(posedge clk); #1;
      bus.mem_write = 1'b0;
      checks++;
      if (bus.mem_rdata !== 8'h3C) begin
         failures++;
         $display("FAIL rst_pre20 got=%h exp=3c", bus.mem_rdata);
      end
      reset         = 1'b1;
      bus.mem_write = 1'b1;
      bus.mem_wdata = 8'h77;
      @(posedge clk); #1;
      reset         = 1'b0;
      bus.mem_write = 1'b0;
      checks++;
      if (bus.mem_rdata !== 8'h00) begin
         failures++;
         $display("FAIL rst_clear20 got=%h exp=00", bus.mem_rdata);
      end
      nonzero = 0;
      for (int a = 0; a < 256; a++) begin
         drive_alu(3'b110, 8'h00, a[7:0], 1'b0);
         if (bus.mem_rdata !== 8'h00) nonzero++;
      end
      checks++;
      if (nonzero !== 0) begin
         failures++;
         $display("FAIL rst_scan nonzero_locations got=%0d exp=0", nonzero);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_wdata = 8'h00;
      drive_alu(3'b000, 8'h00, 8'h00, 1'b0);
      drive_sh(8'h00, 3'd0, 1'b0, 1'b1);
      @(negedge clk);
      test_reset();
      test_alu();
      test_shifter();
      test_mem_write_read();
      test_same_cycle();
      test_reset_discard();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
